// File: rtl/cmp_pkg.sv
// Shared types and constants for the execute-to-complete stage.
// Entry field widths follow the CMP_* constants; the top-level width parameters default to them.
package cmp_pkg;

  localparam int CMP_XLEN   = 32;
  localparam int CMP_PREG_W = 6;
  localparam int CMP_ROB_W  = 6;

  localparam logic [1:0] LDSRC_LSQ   = 2'd0;
  localparam logic [1:0] LDSRC_CACHE = 2'd1;
  localparam logic [1:0] LDSRC_MEM   = 2'd2;

  typedef struct packed {
    logic [CMP_XLEN-1:0]   pc;
    logic [CMP_XLEN-1:0]   data;
    logic [CMP_PREG_W-1:0] dest;
    logic [CMP_ROB_W-1:0]  rob;
  } cmp_entry_t;

endpackage

// File: rtl/cmp_memq.sv
// Memory-completion FIFO: up to two writes and one read per cycle, occupancy exposed as count.
module cmp_memq #(
  parameter int DEPTH = 4,
  parameter int W     = 76,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          wr0_en,
  input  logic [W-1:0]  wr0_data,
  input  logic          wr1_en,
  input  logic [W-1:0]  wr1_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] wr1_ptr_s;

  // second write lands behind the first when both are present
  assign wr1_ptr_s = wr_ptr_r + PW'(wr0_en);
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // pointers and occupancy; flush empties the queue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + PW'(wr0_en) + PW'(wr1_en);
      rd_ptr_r <= rd_ptr_r + PW'(rd_en);
      count_r  <= count_r + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (wr0_en) mem_r[wr_ptr_r] <= wr0_data;
    if (wr1_en) mem_r[wr1_ptr_s] <= wr1_data;
  end

endmodule

// File: rtl/complete_stage_arb_chk.sv
// Protocol and occupancy checks for the complete-stage arbiter.
module complete_stage_arb_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rstn,
  input logic          flush,
  input logic          shared_valid,
  input logic          shared_ready,
  input logic [CW-1:0] count
);

  // sampled each rising edge while out of reset
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (!flush) begin
        a_shared_proto: assert (!(shared_valid && !shared_ready));
      end
      a_count_bound: assert (count <= CW'(DEPTH));
    end
  end

endmodule

// File: rtl/complete_stage_arb.sv
// Execute-to-complete register stage; the last lane is shared between its ALU and queued
// memory completions, with starvation-limited priority and ready-based back-pressure.
module complete_stage_arb
  import cmp_pkg::*;
#(
  parameter int NUM_ALU    = 3,
  parameter int XLEN       = CMP_XLEN,
  parameter int PREG_W     = CMP_PREG_W,
  parameter int ROB_W      = CMP_ROB_W,
  parameter int MEMQ_DEPTH = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic [NUM_ALU-1:0]        alu_valid,
  input  logic [NUM_ALU*XLEN-1:0]   alu_pc,
  input  logic [NUM_ALU*XLEN-1:0]   alu_data,
  input  logic [NUM_ALU*PREG_W-1:0] alu_dest,
  input  logic [NUM_ALU*ROB_W-1:0]  alu_rob,
  output logic                      alu_shared_ready,
  input  logic                      ld_valid,
  input  logic [XLEN-1:0]           ld_pc,
  input  logic [PREG_W-1:0]         ld_dest,
  input  logic [ROB_W-1:0]          ld_rob,
  input  logic [1:0]                ld_src,
  input  logic [XLEN-1:0]           ld_data_lsq,
  input  logic [XLEN-1:0]           ld_data_cache,
  input  logic [XLEN-1:0]           ld_data_mem,
  output logic                      ld_ready,
  input  logic                      st_valid,
  input  logic [XLEN-1:0]           st_pc,
  input  logic [ROB_W-1:0]          st_rob,
  output logic                      st_ready,
  output logic [NUM_ALU-1:0]        cmp_valid,
  output logic [NUM_ALU*XLEN-1:0]   cmp_pc,
  output logic [NUM_ALU*XLEN-1:0]   cmp_data,
  output logic [NUM_ALU*PREG_W-1:0] cmp_dest,
  output logic [NUM_ALU*ROB_W-1:0]  cmp_rob
);

  localparam int S  = NUM_ALU - 1;
  localparam int CW = $clog2(MEMQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int EW = $bits(cmp_entry_t);
  localparam logic [CW-1:0] PRI_CNT    = CW'(MEMQ_DEPTH - 1);
  localparam logic [CW-1:0] ST_MAX_CNT = CW'(MEMQ_DEPTH - 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  logic [CW-1:0] count_s;
  logic [SW-1:0] starve_r;
  logic          mem_pri_s, alu_win_s, pop_s, ld_acc_s, st_acc_s, ld_ready_s, st_ready_s;
  logic [EW-1:0] head_vec_s;
  cmp_entry_t    head_s, ld_ent_s, st_ent_s, alu_ent_s, shr_ent_s, wr0_ent_s;

  logic [NUM_ALU-1:0]        cmp_valid_r;
  logic [NUM_ALU*XLEN-1:0]   cmp_pc_r, cmp_data_r;
  logic [NUM_ALU*PREG_W-1:0] cmp_dest_r;
  logic [NUM_ALU*ROB_W-1:0]  cmp_rob_r;

  // everything below is decided from registered occupancy/starvation, never from this cycle's valids
  assign mem_pri_s        = (count_s >= PRI_CNT) || (starve_r >= STARVE_MAX);
  assign alu_shared_ready = ~mem_pri_s;
  assign ld_ready_s       = (count_s <= PRI_CNT);
  assign st_ready_s       = (count_s <= ST_MAX_CNT);
  assign ld_ready         = ld_ready_s;
  assign st_ready         = st_ready_s;
  assign ld_acc_s         = ld_valid & ld_ready_s & ~flush;
  assign st_acc_s         = st_valid & st_ready_s & ~flush;
  assign head_s           = cmp_entry_t'(head_vec_s);

  assign st_ent_s  = '{pc: st_pc, data: {XLEN{1'b0}}, dest: {PREG_W{1'b0}}, rob: st_rob};
  assign alu_ent_s = '{pc: alu_pc[S*XLEN +: XLEN], data: alu_data[S*XLEN +: XLEN],
                       dest: alu_dest[S*PREG_W +: PREG_W], rob: alu_rob[S*ROB_W +: ROB_W]};

  // load entry with data chosen by source
  always_comb begin
    ld_ent_s.pc   = ld_pc;
    ld_ent_s.dest = ld_dest;
    ld_ent_s.rob  = ld_rob;
    case (ld_src)
      LDSRC_LSQ:         ld_ent_s.data = ld_data_lsq;
      LDSRC_CACHE:       ld_ent_s.data = ld_data_cache;
      LDSRC_MEM, 2'd3:   ld_ent_s.data = ld_data_mem;
      default:           ld_ent_s.data = ld_data_mem;
    endcase
  end

  // load takes the first write slot when present, so it always precedes a same-cycle store
  always_comb begin
    wr0_ent_s = st_ent_s;
    if (ld_acc_s) begin
      wr0_ent_s = ld_ent_s;
    end else begin
      wr0_ent_s = st_ent_s;
    end
  end

  // shared-lane select
  always_comb begin
    alu_win_s = 1'b0;
    pop_s     = 1'b0;
    shr_ent_s = head_s;
    if (flush) begin
      alu_win_s = 1'b0;
      pop_s     = 1'b0;
    end else if (alu_valid[S] && !mem_pri_s) begin
      alu_win_s = 1'b1;
      shr_ent_s = alu_ent_s;
    end else if (count_s != {CW{1'b0}}) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  cmp_memq #(.DEPTH(MEMQ_DEPTH), .W(EW)) u_memq (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .wr0_en   (ld_acc_s | st_acc_s),
    .wr0_data (wr0_ent_s),
    .wr1_en   (ld_acc_s & st_acc_s),
    .wr1_data (st_ent_s),
    .rd_en    (pop_s),
    .rd_data  (head_vec_s),
    .count    (count_s)
  );

  // starvation counter for a waiting FIFO head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_r <= {SW{1'b0}};
    end else if (flush || pop_s || (count_s == {CW{1'b0}})) begin
      starve_r <= {SW{1'b0}};
    end else if (starve_r < STARVE_MAX) begin
      starve_r <= starve_r + SW'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // completion output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_valid_r <= {NUM_ALU{1'b0}};
      cmp_pc_r    <= {(NUM_ALU*XLEN){1'b0}};
      cmp_data_r  <= {(NUM_ALU*XLEN){1'b0}};
      cmp_dest_r  <= {(NUM_ALU*PREG_W){1'b0}};
      cmp_rob_r   <= {(NUM_ALU*ROB_W){1'b0}};
    end else begin
      for (int i = 0; i < S; i++) begin
        cmp_valid_r[i]                <= alu_valid[i] & ~flush;
        cmp_pc_r[i*XLEN +: XLEN]      <= alu_pc[i*XLEN +: XLEN];
        cmp_data_r[i*XLEN +: XLEN]    <= alu_data[i*XLEN +: XLEN];
        cmp_dest_r[i*PREG_W +: PREG_W] <= alu_dest[i*PREG_W +: PREG_W];
        cmp_rob_r[i*ROB_W +: ROB_W]   <= alu_rob[i*ROB_W +: ROB_W];
      end
      cmp_valid_r[S] <= alu_win_s | pop_s;
      if (alu_win_s | pop_s) begin
        cmp_pc_r[S*XLEN +: XLEN]       <= shr_ent_s.pc;
        cmp_data_r[S*XLEN +: XLEN]     <= shr_ent_s.data;
        cmp_dest_r[S*PREG_W +: PREG_W] <= shr_ent_s.dest;
        cmp_rob_r[S*ROB_W +: ROB_W]    <= shr_ent_s.rob;
      end
    end
  end

  assign cmp_valid = cmp_valid_r;
  assign cmp_pc    = cmp_pc_r;
  assign cmp_data  = cmp_data_r;
  assign cmp_dest  = cmp_dest_r;
  assign cmp_rob   = cmp_rob_r;

  complete_stage_arb_chk #(.DEPTH(MEMQ_DEPTH), .CW(CW)) u_chk (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .shared_valid (alu_valid[S]),
    .shared_ready (alu_shared_ready),
    .count        (count_s)
  );

endmodule
